// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the MEM stage: byte/half/word loads and stores
// against a word-organised RAM with a fixed access latency and a ready handshake.
module data_mem_ctrl #(
  parameter int DM_MEM_DEPTH = 4096,
  parameter int DATA_WIDTH   = 32,
  parameter int FUNC3_WIDTH  = 3,
  parameter int LATENCY      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memReadMeM,
  input  logic                   memWriteMeM,
  input  logic [FUNC3_WIDTH-1:0] func3MeM,
  input  logic [DATA_WIDTH-1:0]  aluOutMeM,
  input  logic [DATA_WIDTH-1:0]  rs2DataMeM,
  output logic [DATA_WIDTH-1:0]  dMOutMem,
  output logic                   dMReadyMem,
  output logic                   memErrorMem
);

  localparam int AW = $clog2(DM_MEM_DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} stateT;

  stateT                  stateReg;
  logic [3:0]             cntReg;
  logic [AW+1:0]          addrReg;
  logic [DATA_WIDTH-1:0]  wdataReg;
  logic [FUNC3_WIDTH-1:0] func3Reg;
  logic                   readReg;
  logic                   writeReg;

  logic                   errReg;
  logic                   outZero;
  logic [FUNC3_WIDTH-1:0] outFunc3;
  logic [1:0]             outLane;

  logic                   reqIn;
  logic                   inIdle;
  logic                   goDone;
  logic                   memWe;
  logic [AW+1:0]          effAddr;
  logic [DATA_WIDTH-1:0]  effWdata;
  logic [FUNC3_WIDTH-1:0] effFunc3;
  logic                   effRead;
  logic                   effWrite;
  logic [AW-1:0]          effIdx;
  logic [1:0]             effLane;
  logic                   fault;
  logic [3:0]             byteEn;
  logic [DATA_WIDTH-1:0]  wordWdata;
  logic                   unusedAddrBits;

  assign unusedAddrBits = ^aluOutMeM[DATA_WIDTH-1:AW+2];

  assign reqIn  = memReadMeM | memWriteMeM;
  assign inIdle = (stateReg == IDLE);

  // In IDLE the live request is decoded so LATENCY=1 can complete on the accept edge.
  assign effAddr  = inIdle ? aluOutMeM[AW+1:0] : addrReg;
  assign effWdata = inIdle ? rs2DataMeM : wdataReg;
  assign effFunc3 = inIdle ? func3MeM : func3Reg;
  assign effRead  = inIdle ? memReadMeM : readReg;
  assign effWrite = inIdle ? memWriteMeM : writeReg;
  assign effIdx   = effAddr[AW+1:2];
  assign effLane  = effAddr[1:0];

  assign goDone = (inIdle && reqIn && (LATENCY == 1)) ||
                  ((stateReg == BUSY) && (cntReg == 4'd1));

  always_comb begin
    fault = 1'b0;
    if (effRead && effWrite) begin
      fault = 1'b1;
    end else if (effRead) begin
      case (effFunc3)
        3'b000, 3'b100: fault = 1'b0;
        3'b001, 3'b101: fault = effLane[0];
        3'b010:         fault = (effLane != 2'b00);
        default:        fault = 1'b1;
      endcase
    end else if (effWrite) begin
      case (effFunc3)
        3'b000:  fault = 1'b0;
        3'b001:  fault = effLane[0];
        3'b010:  fault = (effLane != 2'b00);
        default: fault = 1'b1;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick placement.
  always_comb begin
    byteEn    = 4'b0000;
    wordWdata = effWdata;
    case (effFunc3[1:0])
      2'b00: begin
        byteEn    = 4'b0001 << effLane;
        wordWdata = {4{effWdata[7:0]}};
      end
      2'b01: begin
        byteEn    = effLane[1] ? 4'b1100 : 4'b0011;
        wordWdata = {2{effWdata[15:0]}};
      end
      default: byteEn = 4'b1111;
    endcase
  end

  assign memWe = !rst && goDone && effWrite && !fault;

  logic [DATA_WIDTH-1:0] mem [DM_MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdWord;

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[effIdx][i*8 +: 8] <= wordWdata[i*8 +: 8];
      end
    end
    if (goDone) rdWord <= mem[effIdx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      addrReg  <= '0;
      wdataReg <= '0;
      func3Reg <= '0;
      readReg  <= 1'b0;
      writeReg <= 1'b0;
      errReg   <= 1'b0;
      outZero  <= 1'b1;
      outFunc3 <= '0;
      outLane  <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (reqIn) begin
            addrReg  <= aluOutMeM[AW+1:0];
            wdataReg <= rs2DataMeM;
            func3Reg <= func3MeM;
            readReg  <= memReadMeM;
            writeReg <= memWriteMeM;
            cntReg   <= CNT_INIT;
            stateReg <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cntReg <= cntReg - 4'd1;
          if (cntReg == 4'd1) stateReg <= DONE;
        end
        DONE: begin
          stateReg <= IDLE;
          errReg   <= 1'b0;
        end
        default: stateReg <= IDLE;
      endcase
      if (goDone) begin
        errReg   <= fault;
        outZero  <= fault | effWrite;
        outFunc3 <= effFunc3;
        outLane  <= effLane;
      end
    end
  end

  logic [7:0]  laneBytes [4];
  logic [7:0]  selByte;
  logic [15:0] selHalf;

  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    assign laneBytes[gi] = rdWord[gi*8 +: 8];
  end

  assign selByte = laneBytes[outLane];
  assign selHalf = outLane[1] ? rdWord[31:16] : rdWord[15:0];

  // Output is shaped from state captured entering DONE, so it holds until the next access.
  always_comb begin
    dMOutMem = '0;
    if (!outZero) begin
      case (outFunc3)
        3'b000:  dMOutMem = {{24{selByte[7]}}, selByte};
        3'b001:  dMOutMem = {{16{selHalf[15]}}, selHalf};
        3'b100:  dMOutMem = {24'b0, selByte};
        3'b101:  dMOutMem = {16'b0, selHalf};
        default: dMOutMem = rdWord;
      endcase
    end
  end

  assign memErrorMem = errReg;
  assign dMReadyMem  = !rst && ((inIdle && !reqIn) || (stateReg == DONE));

endmodule
